// File: rtl/prewish5k_mask_scheduler_if.sv
// Strobe/data bus used on both sides of the mask scheduler:
// user requests on the way in, mentor writes on the way out.
interface prewish5k_mask_scheduler_if;
  logic       stb;
  logic [7:0] dat;

  modport master (output stb, dat);
  modport slave  (input  stb, dat);
endinterface

// File: rtl/prewish5k_mask_scheduler.sv
// Arbitrates user and playlist-replay mask writes toward the mentor and
// enforces a minimum idle gap between successive mentor strobes.
module prewish5k_mask_scheduler #(
  parameter int unsigned DWELL_BITS = 23,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned ALIVE_BITS = 22
) (
  input  logic                              CLK_I,
  input  logic                              RST_I,
  prewish5k_mask_scheduler_if.slave         usr,
  prewish5k_mask_scheduler_if.master        mnt,
  input  logic                              i_auto,
  input  logic                              i_clear,
  output logic [2:0]                        o_count,
  output logic                              o_alive
);

  localparam int unsigned GAP_W    = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam int unsigned SLOTS    = 4;
  localparam int unsigned PTR_W    = 2;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned MASK_W   = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [GAP_W-1:0]        gap_q, gap_d;

  logic [MASK_W-1:0]       slot_q [SLOTS];
  logic [CNT_W-1:0]        count_q;
  logic [PTR_W-1:0]        wr_ptr_q;
  logic [PTR_W-1:0]        play_ptr_q;
  logic                    user_pend_q;
  logic [MASK_W-1:0]       user_dat_q;
  logic                    auto_pend_q;
  logic [DWELL_BITS-1:0]   dwell_q;
  logic [ALIVE_BITS-1:0]   alive_q;
  logic                    stb_q;
  logic [MASK_W-1:0]       dat_q;

  logic                    tick_c;
  logic                    user_req_c;
  logic [MASK_W-1:0]       user_dat_c;
  logic                    auto_req_c;
  logic                    decide_c;
  logic                    issue_user_c;
  logic                    issue_auto_c;
  logic [CNT_W-1:0]        count_base_c;
  logic [PTR_W-1:0]        wr_base_c;
  logic [CNT_W-1:0]        play_inc_c;

  assign tick_c       = i_auto && (&dwell_q);
  assign user_req_c   = usr.stb || user_pend_q;
  assign user_dat_c   = usr.stb ? usr.dat : user_dat_q;
  // A clear in the deciding cycle empties the playlist, so it also vetoes replay.
  assign auto_req_c   = i_auto && !i_clear && (count_q != CNT_W'(0)) && (auto_pend_q || tick_c);
  assign count_base_c = i_clear ? CNT_W'(0) : count_q;
  assign wr_base_c    = i_clear ? PTR_W'(0) : wr_ptr_q;
  assign play_inc_c   = CNT_W'(play_ptr_q) + CNT_W'(1);

  // State register
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // Next state; the last gap cycle can launch the next issue directly
  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    decide_c     = 1'b0;
    issue_user_c = 1'b0;
    issue_auto_c = 1'b0;
    case (state_q)
      S_IDLE:  decide_c = 1'b1;
      S_ISSUE: begin
        state_d = S_GAP;
        gap_d   = GAP_W'(GAP_CYCLES - 1);
      end
      S_GAP: begin
        if (gap_q == GAP_W'(0)) begin
          decide_c = 1'b1;
          state_d  = S_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (decide_c) begin
      issue_user_c = user_req_c;
      issue_auto_c = !user_req_c && auto_req_c;
      if (issue_user_c || issue_auto_c) state_d = S_ISSUE;
    end
  end

  // Request flags, pointers, counters and mentor outputs
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      play_ptr_q  <= '0;
      user_pend_q <= 1'b0;
      user_dat_q  <= '0;
      auto_pend_q <= 1'b0;
      dwell_q     <= '0;
      alive_q     <= '0;
      stb_q       <= 1'b0;
      dat_q       <= '0;
    end else begin
      alive_q <= alive_q + ALIVE_BITS'(1);
      stb_q   <= issue_user_c || issue_auto_c;

      if (issue_user_c)      dat_q <= user_dat_c;
      else if (issue_auto_c) dat_q <= slot_q[play_ptr_q];

      if (issue_user_c)  user_pend_q <= 1'b0;
      else if (usr.stb)  user_pend_q <= 1'b1;
      if (usr.stb)       user_dat_q  <= usr.dat;

      if (!i_auto || i_clear || issue_auto_c)         auto_pend_q <= 1'b0;
      else if (tick_c && (count_q != CNT_W'(0)))      auto_pend_q <= 1'b1;

      if (!i_auto || issue_user_c) dwell_q <= '0;
      else                         dwell_q <= dwell_q + DWELL_BITS'(1);

      if (i_clear)           play_ptr_q <= '0;
      else if (issue_auto_c) play_ptr_q <= (play_inc_c >= count_q) ? PTR_W'(0) : play_inc_c[PTR_W-1:0];

      count_q  <= count_base_c;
      wr_ptr_q <= wr_base_c;
      if (usr.stb) begin
        count_q  <= (count_base_c == CNT_W'(SLOTS)) ? CNT_W'(SLOTS) : count_base_c + CNT_W'(1);
        wr_ptr_q <= wr_base_c + PTR_W'(1);
      end
    end
  end

  // Playlist storage; o_count decides which slots are meaningful
  always_ff @(posedge CLK_I) begin
    if (usr.stb) slot_q[wr_base_c] <= usr.dat;
  end

  assign mnt.stb = stb_q;
  assign mnt.dat = dat_q;
  assign o_count = count_q;
  assign o_alive = alive_q[ALIVE_BITS-1];

endmodule

// File: tb/tb_prewish5k_mask_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// cycle by cycle against a timestamp-based behavioural model.
module tb_prewish5k_mask_scheduler;

  localparam int DW   = 4;
  localparam int GAP  = 2;
  localparam int AB   = 5;
  localparam int DMAX = (1 << DW) - 1;

  logic       clk;
  logic       rst;
  logic       i_auto;
  logic       i_clear;
  logic [2:0] o_count;
  logic       o_alive;

  prewish5k_mask_scheduler_if usr_bus ();
  prewish5k_mask_scheduler_if mnt_bus ();

  prewish5k_mask_scheduler #(
    .DWELL_BITS (DW),
    .GAP_CYCLES (GAP),
    .ALIVE_BITS (AB)
  ) dut (
    .CLK_I   (clk),
    .RST_I   (rst),
    .usr     (usr_bus),
    .mnt     (mnt_bus),
    .i_auto  (i_auto),
    .i_clear (i_clear),
    .o_count (o_count),
    .o_alive (o_alive)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_no   = 0;

  // Model: playlist as an array, gap enforced by the time of the last pulse
  int m_slot [4];
  int m_cnt, m_wr, m_play;
  int m_upend, m_udat, m_apend, m_dwell, m_alive;
  int m_last_pulse;
  int exp_stb, exp_dat;

  byte unsigned obs_d[$];
  int           obs_c[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc_no);
    end
  endtask

  function automatic void model_step(input bit r, input bit s, input int d, input bit a, input bit c);
    bit tick, ureq, areq, can, iu, ia;
    int ud;
    if (r) begin
      m_cnt = 0; m_wr = 0; m_play = 0; m_upend = 0; m_udat = 0;
      m_apend = 0; m_dwell = 0; m_alive = 0; m_last_pulse = -100;
      exp_stb = 0; exp_dat = 0;
      return;
    end
    tick = a && (m_dwell == DMAX);
    ureq = s || (m_upend != 0);
    ud   = s ? d : m_udat;
    areq = a && !c && (m_cnt != 0) && ((m_apend != 0) || tick);
    can  = (cyc_no >= m_last_pulse + GAP);
    iu   = can && ureq;
    ia   = can && !ureq && areq;
    exp_stb = (iu || ia) ? 1 : 0;
    if (iu) exp_dat = ud;
    if (ia) exp_dat = m_slot[m_play];
    if (iu || ia) m_last_pulse = cyc_no + 1;
    if (c) m_play = 0;
    else if (ia) m_play = (m_play + 1 >= m_cnt) ? 0 : m_play + 1;
    if (!a || c || ia) m_apend = 0;
    else if (tick && m_cnt != 0) m_apend = 1;
    if (iu) m_upend = 0;
    else if (s) m_upend = 1;
    if (s) m_udat = d;
    m_dwell = (!a || iu) ? 0 : (m_dwell + 1) % (DMAX + 1);
    if (c) begin m_cnt = 0; m_wr = 0; end
    if (s) begin
      m_slot[m_wr] = d;
      m_wr  = (m_wr + 1) % 4;
      m_cnt = (m_cnt >= 4) ? 4 : m_cnt + 1;
    end
    m_alive = (m_alive + 1) % (1 << AB);
  endfunction

  task automatic step(input bit r, input bit s, input logic [7:0] d, input bit a, input bit c);
    rst = r; usr_bus.stb = s; usr_bus.dat = d; i_auto = a; i_clear = c;
    @(posedge clk);
    model_step(r, s, int'(d), a, c);
    #1;
    check("stb_o", 32'(mnt_bus.stb), 32'(exp_stb));
    check("dat_o", 32'(mnt_bus.dat), 32'(exp_dat));
    check("count", 32'(o_count), 32'(m_cnt));
    check("alive", 32'(o_alive), 32'((m_alive >> (AB - 1)) & 1));
    if (mnt_bus.stb) begin
      obs_d.push_back(mnt_bus.dat);
      obs_c.push_back(cyc_no);
    end
    cyc_no++;
  endtask

  task automatic idle(input int n, input bit a);
    repeat (n) step(1'b0, 1'b0, 8'h00, a, 1'b0);
  endtask

  task automatic do_reset();
    repeat (3) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [7:0] d);
    step(1'b0, 1'b1, d, 1'b0, 1'b0);
    idle(4, 1'b0);
  endtask

  initial begin
    rst = 1'b1; usr_bus.stb = 1'b0; usr_bus.dat = 8'h00; i_auto = 1'b0; i_clear = 1'b0;

    // Reset state and quiet idle
    do_reset();
    check("rst_stb", 32'(mnt_bus.stb), 32'd0);
    check("rst_dat", 32'(mnt_bus.dat), 32'h00);
    check("rst_cnt", 32'(o_count), 32'd0);
    obs_d.delete(); obs_c.delete();
    idle(40, 1'b0);
    check("quiet_pulses", 32'(obs_d.size()), 32'd0);

    // Single user write, one-cycle latency
    step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
    check("a5_stb", 32'(mnt_bus.stb), 32'd1);
    check("a5_dat", 32'(mnt_bus.dat), 32'hA5);
    idle(1, 1'b0);
    check("a5_single", 32'(mnt_bus.stb), 32'd0);
    check("a5_cnt", 32'(o_count), 32'd1);

    // Back-to-back requests: newest pending one wins after the gap
    do_reset(); idle(2, 1'b0);
    obs_d.delete(); obs_c.delete();
    step(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
    idle(6, 1'b0);
    check("b2b_n", 32'(obs_d.size()), 32'd2);
    if (obs_d.size() == 2) begin
      check("b2b_0", 32'(obs_d[0]), 32'h11);
      check("b2b_1", 32'(obs_d[1]), 32'h33);
      check("b2b_space", 32'(obs_c[1] - obs_c[0]), 32'd3);
    end
    check("b2b_cnt", 32'(o_count), 32'd3);

    // Auto replay of three masks on the dwell timer
    do_reset();
    load(8'h01); load(8'h02); load(8'h03);
    obs_d.delete(); obs_c.delete();
    idle(70, 1'b1);
    check("auto3_n", 32'(obs_d.size()), 32'd4);
    if (obs_d.size() == 4) begin
      check("auto3_0", 32'(obs_d[0]), 32'h01);
      check("auto3_1", 32'(obs_d[1]), 32'h02);
      check("auto3_2", 32'(obs_d[2]), 32'h03);
      check("auto3_3", 32'(obs_d[3]), 32'h01);
      for (int i = 1; i < 4; i++) check("auto3_space", 32'(obs_c[i] - obs_c[i-1]), 32'd16);
    end

    // Overwrite of oldest slots, replay from slot 0
    do_reset();
    for (int i = 0; i < 6; i++) load(8'(8'h10 + i));
    check("ovw_cnt", 32'(o_count), 32'd4);
    obs_d.delete(); obs_c.delete();
    idle(70, 1'b1);
    check("ovw_n", 32'(obs_d.size()), 32'd4);
    if (obs_d.size() == 4) begin
      check("ovw_0", 32'(obs_d[0]), 32'h14);
      check("ovw_1", 32'(obs_d[1]), 32'h15);
      check("ovw_2", 32'(obs_d[2]), 32'h12);
      check("ovw_3", 32'(obs_d[3]), 32'h13);
    end

    // User collides with a tick, then clear together with a new write
    do_reset();
    load(8'h40);
    obs_d.delete(); obs_c.delete();
    idle(15, 1'b1);
    step(1'b0, 1'b1, 8'h7E, 1'b1, 1'b0);
    idle(6, 1'b1);
    step(1'b0, 1'b1, 8'h99, 1'b1, 1'b1);
    check("clr_cnt", 32'(o_count), 32'd1);
    idle(25, 1'b1);
    check("col_n", 32'(obs_d.size()), 32'd4);
    if (obs_d.size() == 4) begin
      check("col_user", 32'(obs_d[0]), 32'h7E);
      check("col_auto", 32'(obs_d[1]), 32'h40);
      check("col_space", 32'(obs_c[1] - obs_c[0]), 32'd3);
      check("clr_user", 32'(obs_d[2]), 32'h99);
      check("clr_auto", 32'(obs_d[3]), 32'h99);
    end

    // Randomized traffic against the model
    do_reset();
    begin
      bit a = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 99) == 0) a = ~a;
        step(($urandom_range(0, 499) == 0), ($urandom_range(0, 4) == 0),
             8'($urandom), a, ($urandom_range(0, 59) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
